// File: rtl/simd_pkg.sv
// ---------------------------------------------------------------------------
// simd_pkg
// Shared definitions for the SIMD execute/write-back stage:
//   XLEN_DEF / LANE_W_DEF / NUM_LANES_DEF : default datapath geometry
//   REG_ADDR_W / NUM_REGS                : architectural register file shape
//   op_e                                 : resolved operation
//   state_e                              : stage FSM state
//   decode_op()                          : resolves the decoder's one-hot-ish
//                                          enables with add > bitrev > mul > sub
// ---------------------------------------------------------------------------
package simd_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int LANE_W_DEF    = 8;
   localparam int NUM_LANES_DEF = XLEN_DEF / LANE_W_DEF;
   localparam int REG_ADDR_W    = 5;
   localparam int NUM_REGS      = 32;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_BITREV
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      EX,
      MUL
   } state_e;

   // Same priority order the decoder uses when several enables are set.
   function automatic op_e decode_op(input logic add_en,
                                     input logic sub_en,
                                     input logic mul_en,
                                     input logic bitrev_en);
      op_e op;
      if (add_en)         op = OP_ADD;
      else if (bitrev_en) op = OP_BITREV;
      else if (mul_en)    op = OP_MUL;
      else if (sub_en)    op = OP_SUB;
      else                op = OP_NONE;
      return op;
   endfunction

endpackage

// File: rtl/simd_exec_stage_if.sv
// ---------------------------------------------------------------------------
// simd_exec_stage_if
// Decoder-to-execute handshake plus write-back report.
//   in_valid / in_ready                      : instruction handshake
//   add_en, sub_en, mul_en, bitrev_en        : op selects from the decoder
//   rs1_rd_en, rs2_rd_en, rd_wr_en           : operand read / dest write enables
//   rs1, rs2, rd                             : register addresses
//   wb_valid, wb_rd, wb_data                 : write-back pulse, dest, value
// master = decoder side, slave = execute stage.
// ---------------------------------------------------------------------------
interface simd_exec_stage_if
   import simd_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);

   logic                  in_valid;
   logic                  in_ready;
   logic                  add_en;
   logic                  sub_en;
   logic                  mul_en;
   logic                  bitrev_en;
   logic                  rs1_rd_en;
   logic                  rs2_rd_en;
   logic                  rd_wr_en;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [REG_ADDR_W-1:0] rd;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]       wb_data;

   modport master (
      output in_valid, add_en, sub_en, mul_en, bitrev_en,
             rs1_rd_en, rs2_rd_en, rd_wr_en, rs1, rs2, rd,
      input  in_ready, wb_valid, wb_rd, wb_data
   );

   modport slave (
      input  in_valid, add_en, sub_en, mul_en, bitrev_en,
             rs1_rd_en, rs2_rd_en, rd_wr_en, rs1, rs2, rd,
      output in_ready, wb_valid, wb_rd, wb_data
   );

endinterface

// File: rtl/simd_lane_alu.sv
// ---------------------------------------------------------------------------
// simd_lane_alu
// Combinational single-lane ALU.
//   op : resolved operation (op_e)
//   a  : lane of rs1
//   b  : lane of rs2 (ignored for bitrev)
//   y  : lane result
// Optional macro SIMD_SAT_EN: add/sub saturate as unsigned (add clamps at
// all-ones, sub clamps at zero). Without it both wrap modulo 2^LANE_W.
// ---------------------------------------------------------------------------
module simd_lane_alu
   import simd_pkg::*;
#(
   parameter int LANE_W = LANE_W_DEF
) (
   input  op_e               op,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] y
);

   logic [LANE_W-1:0] add_res;
   logic [LANE_W-1:0] sub_res;
   logic [LANE_W-1:0] mul_res;
   logic [LANE_W-1:0] rev_res;

`ifdef SIMD_SAT_EN
   // One extra bit captures carry-out / borrow-out for clamping.
   logic [LANE_W:0] sum_ext;
   logic [LANE_W:0] diff_ext;

   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};
   assign add_res  = sum_ext[LANE_W]  ? {LANE_W{1'b1}} : sum_ext[LANE_W-1:0];
   assign sub_res  = diff_ext[LANE_W] ? '0             : diff_ext[LANE_W-1:0];
`else
   assign add_res = a + b;
   assign sub_res = a - b;
`endif

   // Low LANE_W bits of the unsigned product.
   assign mul_res = a * b;

   for (genvar gi = 0; gi < LANE_W; gi++) begin : g_rev
      assign rev_res[gi] = a[LANE_W-1-gi];
   end

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:    y = add_res;
         OP_SUB:    y = sub_res;
         OP_MUL:    y = mul_res;
         OP_BITREV: y = rev_res;
         default:   y = '0;
      endcase
   end

endmodule

// File: rtl/simd_exec_stage.sv
// ---------------------------------------------------------------------------
// simd_exec_stage
// Execute/write-back stage behind the SIMD decoder. Owns the 32-entry
// register file, captures operands on accept, runs a lane-wise ALU and
// writes the result back. add/sub/bitrev take one EX cycle (1 op/cycle);
// mul spends MUL_LAT cycles in MUL and holds in_ready low until its last one.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : simd_exec_stage_if.slave (handshake, operands, write-back)
//   busy       : EX or MUL occupied
//   dbg_addr   : debug register read address
//   dbg_data   : regfile[dbg_addr], 0 for x0
// Optional macro SIMD_SAT_EN (see simd_lane_alu) selects saturating add/sub.
// ---------------------------------------------------------------------------
module simd_exec_stage
   import simd_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int LANE_W  = LANE_W_DEF,
   parameter int MUL_LAT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   simd_exec_stage_if.slave      bus,
   output logic                  busy,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [XLEN-1:0]       dbg_data
);

   localparam int NUM_LANES = XLEN / LANE_W;
   localparam int CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

   state_e                state_reg;
   op_e                   op_reg;
   logic [XLEN-1:0]       a_reg;
   logic [XLEN-1:0]       b_reg;
   logic [REG_ADDR_W-1:0] rd_reg;
   logic                  wr_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [XLEN-1:0]       regfile_reg [NUM_REGS];

   logic [XLEN-1:0]       result;
   logic [XLEN-1:0]       rs1_val;
   logic [XLEN-1:0]       rs2_val;
   logic                  mul_last;
   logic                  retire;
   logic                  accept;
   op_e                   op_next;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      simd_lane_alu #(
         .LANE_W (LANE_W)
      ) u_lane (
         .op (op_reg),
         .a  (a_reg[gi*LANE_W +: LANE_W]),
         .b  (b_reg[gi*LANE_W +: LANE_W]),
         .y  (result[gi*LANE_W +: LANE_W])
      );
   end

   assign mul_last     = (state_reg == MUL) && (cnt_reg == MUL_LAST);
   assign retire       = (state_reg == EX) || mul_last;
   assign bus.in_ready = (state_reg != MUL) || mul_last;
   assign accept       = bus.in_valid && bus.in_ready;
   assign op_next      = decode_op(bus.add_en, bus.sub_en, bus.mul_en, bus.bitrev_en);

   // wr_reg already excludes rd==0 and no-op instructions.
   assign bus.wb_valid = retire && wr_reg;
   assign bus.wb_rd    = rd_reg;
   assign bus.wb_data  = result;
   assign busy         = (state_reg != IDLE);

   assign dbg_data = (dbg_addr == '0) ? '0 : regfile_reg[dbg_addr];

   // Operand fetch. A result retiring this cycle has not reached the regfile
   // yet, so a matching source takes it straight from the write-back bus.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (bus.rs1_rd_en && (bus.rs1 != '0)) begin
         rs1_val = (bus.wb_valid && (bus.rs1 == rd_reg)) ? result : regfile_reg[bus.rs1];
      end
      if (bus.rs2_rd_en && (bus.rs2 != '0)) begin
         rs2_val = (bus.wb_valid && (bus.rs2 == rd_reg)) ? result : regfile_reg[bus.rs2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regfile_reg[i] <= '0;
         end
      end else if (bus.wb_valid) begin
         regfile_reg[rd_reg] <= result;
      end
   end

   // Stage FSM. A new accept is allowed in any cycle in_ready is high,
   // including the retiring EX / last MUL cycle, which keeps the pipe full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_reg    <= OP_NONE;
         a_reg     <= '0;
         b_reg     <= '0;
         rd_reg    <= '0;
         wr_reg    <= 1'b0;
         cnt_reg   <= '0;
      end else if (accept) begin
         op_reg    <= op_next;
         a_reg     <= rs1_val;
         b_reg     <= rs2_val;
         rd_reg    <= bus.rd;
         wr_reg    <= bus.rd_wr_en && (bus.rd != '0) && (op_next != OP_NONE);
         cnt_reg   <= '0;
         state_reg <= (op_next == OP_MUL) ? MUL : EX;
      end else if (retire) begin
         state_reg <= IDLE;
         wr_reg    <= 1'b0;
      end else if (state_reg == MUL) begin
         cnt_reg   <= cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_simd_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_simd_exec_stage
// Directed and randomized checks of simd_exec_stage against a lane-wise
// arithmetic reference model and a model register file.
// ---------------------------------------------------------------------------
module tb_simd_exec_stage;
   import simd_pkg::*;

   localparam int MUL_LAT = 3;
   localparam int K_NONE = 0, K_ADD = 1, K_SUB = 2, K_MUL = 3, K_BITREV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int total = 0;
   int bad   = 0;
   logic [31:0] model_rf [32];

   always #5 clk = ~clk;

   simd_exec_stage_if #(.XLEN(32)) bus ();

   simd_exec_stage #(
      .XLEN    (32),
      .LANE_W  (8),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .busy     (busy),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Reference: each byte lane treated as an integer 0..255.
   function automatic logic [31:0] ref_op(int kind, logic [31:0] a, logic [31:0] b);
      logic [31:0] res;
      res = '0;
      for (int l = 0; l < 4; l++) begin
         int la, lb, r;
         la = int'((a >> (8*l)) & 32'hFF);
         lb = int'((b >> (8*l)) & 32'hFF);
         r  = 0;
         case (kind)
`ifdef SIMD_SAT_EN
            K_ADD: r = (la + lb > 255) ? 255 : la + lb;
            K_SUB: r = (la - lb < 0) ? 0 : la - lb;
`else
            K_ADD: r = (la + lb) % 256;
            K_SUB: r = (la - lb + 256) % 256;
`endif
            K_MUL: r = (la * lb) % 256;
            K_BITREV: for (int j = 0; j < 8; j++) r = r * 2 + ((la >> j) & 1);
            default: r = 0;
         endcase
         res = res | (32'(r) << (8*l));
      end
      return res;
   endfunction

   function automatic int pick_kind(logic [3:0] ops); // {add,sub,mul,bitrev}
      if (ops[3]) return K_ADD;
      if (ops[0]) return K_BITREV;
      if (ops[1]) return K_MUL;
      if (ops[2]) return K_SUB;
      return K_NONE;
   endfunction

   task automatic drive_idle();
      bus.in_valid = 0; bus.add_en = 0; bus.sub_en = 0; bus.mul_en = 0;
      bus.bitrev_en = 0; bus.rs1_rd_en = 0; bus.rs2_rd_en = 0; bus.rd_wr_en = 0;
      bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
   endtask

   task automatic drive_op(logic [3:0] ops, logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                           logic e1, logic e2, logic ew);
      bus.in_valid = 1;
      {bus.add_en, bus.sub_en, bus.mul_en, bus.bitrev_en} = ops;
      bus.rs1 = r1; bus.rs2 = r2; bus.rd = d;
      bus.rs1_rd_en = e1; bus.rs2_rd_en = e2; bus.rd_wr_en = ew;
   endtask

   // Preload a register behind the stage's back (no load path exists).
   task automatic backdoor(int idx, logic [31:0] v);
      dut.regfile_reg[idx] <= v;
      model_rf[idx] = v;
   endtask

   task automatic check_dbg(string name, logic [4:0] a, logic [31:0] want);
      dbg_addr = a;
      #1;
      total++;
      if (dbg_data !== want) begin
         bad++;
         $display("FAIL %s: dbg x%0d got %h want %h", name, a, dbg_data, want);
      end
   endtask

   // One instruction end to end; returns at a negedge with the stage idle.
   task automatic run_op(string name, logic [3:0] ops, logic [4:0] r1, logic [4:0] r2,
                         logic [4:0] d, logic e1, logic e2, logic ew);
      int kind, exp_lat, guard;
      logic [31:0] a, b, exp;
      logic exp_wb;
      kind    = pick_kind(ops);
      a       = (e1 && r1 != 0) ? model_rf[r1] : 32'h0;
      b       = (e2 && r2 != 0) ? model_rf[r2] : 32'h0;
      exp     = ref_op(kind, a, b);
      exp_wb  = ew && (d != 0) && (kind != K_NONE);
      exp_lat = (kind == K_MUL) ? MUL_LAT : 1;

      @(negedge clk);
      drive_op(ops, r1, r2, d, e1, e2, ew);
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 20) begin
         bad++;
         $display("FAIL %s: in_ready timeout got 0 want 1", name);
      end
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      for (int lat = 1; lat <= exp_lat + 1; lat++) begin
         logic want_v;
         want_v = exp_wb && (lat == exp_lat);
         total++;
         if (bus.wb_valid !== want_v) begin
            bad++;
            $display("FAIL %s: wb_valid at cycle %0d got %b want %b", name, lat, bus.wb_valid, want_v);
         end
         if (want_v) begin
            total++;
            if (bus.wb_rd !== d || bus.wb_data !== exp) begin
               bad++;
               $display("FAIL %s: wb got rd=%0d data=%h want rd=%0d data=%h",
                        name, bus.wb_rd, bus.wb_data, d, exp);
            end
         end
         if (kind != K_NONE) begin
            total++;
            if (busy !== (lat <= exp_lat)) begin
               bad++;
               $display("FAIL %s: busy at cycle %0d got %b want %b", name, lat, busy, lat <= exp_lat);
            end
         end
         if (kind == K_MUL && lat <= exp_lat) begin
            total++;
            if (bus.in_ready !== (lat == exp_lat)) begin
               bad++;
               $display("FAIL %s: in_ready at cycle %0d got %b want %b", name, lat, bus.in_ready, lat == exp_lat);
            end
         end
         if (lat <= exp_lat) @(negedge clk);
      end
      if (exp_wb) model_rf[d] = exp;
      check_dbg(name, d, model_rf[d]);
      $display("op %s: kind=%0d rs1=x%0d rs2=x%0d rd=x%0d wb=%b data=%h", name, kind, r1, r2, d, exp_wb, exp);
   endtask

   task automatic test_reset();
      drive_idle();
      dbg_addr = 0;
      rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset ctl: in_ready=%b wb_valid=%b busy=%b want 1 0 0", bus.in_ready, bus.wb_valid, busy);
      end
      total++;
      if (bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
         bad++;
         $display("FAIL reset wb: rd=%0d data=%h want 0 0", bus.wb_rd, bus.wb_data);
      end
      for (int i = 0; i < 32; i++) model_rf[i] = 0;
      check_dbg("reset x0", 0, 32'h0);
      check_dbg("reset x1", 1, 32'h0);
      $display("reset: checked");
   endtask

   task automatic load_plan();
      @(negedge clk);
      backdoor(1, 32'h01FF7F10);
      backdoor(2, 32'h01010101);
      @(negedge clk);
   endtask

   task automatic test_add();
      load_plan();
      run_op("add", 4'b1000, 1, 2, 3, 1, 1, 1);
`ifdef SIMD_SAT_EN
      check_dbg("add const", 3, 32'h02FF8011);
`else
      check_dbg("add const", 3, 32'h02008011);
`endif
   endtask

   task automatic test_sub();
      @(negedge clk);
      backdoor(1, 32'h00000010);
      run_op("sub", 4'b0100, 1, 2, 4, 1, 1, 1);
`ifdef SIMD_SAT_EN
      check_dbg("sub const", 4, 32'h0000000F);
`else
      check_dbg("sub const", 4, 32'hFFFFFF0F);
`endif
   endtask

   task automatic test_mul();
      @(negedge clk);
      backdoor(1, 32'h02030405);
      backdoor(2, 32'h03030303);
      run_op("mul", 4'b0010, 1, 2, 5, 1, 1, 1);
      check_dbg("mul const", 5, 32'h06090C0F);
   endtask

   task automatic test_bitrev();
      @(negedge clk);
      backdoor(1, 32'h01800F00);
      backdoor(2, $urandom);
      run_op("bitrev", 4'b0001, 1, 2, 6, 1, 1, 1);
      check_dbg("bitrev const", 6, 32'h8001F000);
   endtask

   task automatic test_back_to_back();
      logic [31:0] x7, x8;
      load_plan();
      x7 = ref_op(K_ADD, model_rf[1], model_rf[2]);
      x8 = ref_op(K_ADD, x7, model_rf[2]);
      drive_op(4'b1000, 1, 2, 7, 1, 1, 1);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== x7 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b first: wb_valid=%b data=%h ready=%b want 1 %h 1", bus.wb_valid, bus.wb_data, bus.in_ready, x7);
      end
      drive_op(4'b1000, 7, 2, 8, 1, 1, 1);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd8 || bus.wb_data !== x8) begin
         bad++;
         $display("FAIL b2b forward: wb_valid=%b rd=%0d data=%h want 1 8 %h", bus.wb_valid, bus.wb_rd, bus.wb_data, x8);
      end
      drive_op(4'b1000, 1, 2, 0, 1, 1, 1);
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      total++;
      if (bus.wb_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b x0 write: wb_valid got %b want 0", bus.wb_valid);
      end
      model_rf[7] = x7;
      model_rf[8] = x8;
      @(negedge clk);
`ifdef SIMD_SAT_EN
      check_dbg("b2b x8 const", 8, 32'h03FF8112);
`else
      check_dbg("b2b x8 const", 8, 32'h03018112);
`endif
      check_dbg("b2b x7", 7, x7);
      check_dbg("b2b x0", 0, 32'h0);
      $display("b2b: x7=%h x8=%h", x7, x8);
   endtask

   task automatic test_reset_mid_mul();
      load_plan();
      drive_op(4'b0010, 1, 2, 9, 1, 1, 1);
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      @(negedge clk);                  // MUL cycle 2
      rst_n = 0;
      #1;
      total++;
      if (bus.wb_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midmul reset: wb_valid=%b busy=%b want 0 0", bus.wb_valid, busy);
      end
      @(negedge clk);
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midmul after: wb_valid=%b in_ready=%b busy=%b want 0 1 0", bus.wb_valid, bus.in_ready, busy);
         end
      end
      for (int i = 0; i < 32; i++) model_rf[i] = 0;
      for (int i = 0; i < 32; i++) check_dbg("midmul regs", 5'(i), 32'h0);
      $display("midmul reset: checked");
   endtask

   task automatic test_random();
      @(negedge clk);
      for (int i = 1; i < 32; i++) backdoor(i, $urandom);
      @(negedge clk);
      for (int n = 0; n < 40; n++) begin
         logic [3:0] ops;
         logic [4:0] r1, r2, d;
         logic e1, e2, ew;
         ops = 4'($urandom_range(0, 15));
         r1  = 5'($urandom_range(0, 31));
         r2  = 5'($urandom_range(0, 31));
         d   = 5'($urandom_range(0, 31));
         e1  = ($urandom_range(0, 3) != 0);
         e2  = ($urandom_range(0, 3) != 0);
         ew  = ($urandom_range(0, 7) != 0);
         run_op("rand", ops, r1, r2, d, e1, e2, ew);
      end
   endtask

   initial begin
      drive_idle();
      dbg_addr = 0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_bitrev();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
